// File: rtl/timer_intr_ctrl_if.sv
// Data-bus port bundle for the machine-timer window.
// The core drives address/strobes; the timer returns load data and a hit flag.
interface timer_intr_ctrl_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rdata;
  logic        bus_sel;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_wr,
    output bus_rd,
    input  bus_rdata,
    input  bus_sel
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_wr,
    input  bus_rd,
    output bus_rdata,
    output bus_sel
  );
endinterface

// File: rtl/timer_intr_ctrl.sv
// Machine timer (mtime/mtimecmp) with prescaler and trap-request FSM.
// Feeds mip.MTIP and the one-cycle intr_exc request into csr.
module timer_intr_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  timer_intr_ctrl_if.slave    bus,
  input  logic                glb_ie,
  input  logic                stall,
  input  logic                mret,
  output logic                timer_irq,
  output logic                intr_exc
);

  typedef enum logic {
    IDLE,
    TRAP
  } state_t;

  state_t state;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [63:0]           mtime_n;
  logic [63:0]           cmp_n;
  logic                  en;
  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           ctrl_val;

  logic [4:0] off;
  logic       sel;
  logic       hit_tlo;
  logic       hit_thi;
  logic       hit_clo;
  logic       hit_chi;
  logic       hit_ctl;
  logic       wr_tlo;
  logic       wr_thi;
  logic       wr_clo;
  logic       wr_chi;
  logic       wr_ctl;
  logic       tick;
  logic       trap_req;

  assign off     = bus.bus_addr[4:0];
  assign sel     = bus.bus_addr[31:5] == BASE_ADDR[31:5];
  assign bus.bus_sel = sel;

  assign hit_tlo = sel && off == 5'h00;
  assign hit_thi = sel && off == 5'h04;
  assign hit_clo = sel && off == 5'h08;
  assign hit_chi = sel && off == 5'h0C;
  assign hit_ctl = sel && off == 5'h10;

  assign wr_tlo  = bus.bus_wr && hit_tlo;
  assign wr_thi  = bus.bus_wr && hit_thi;
  assign wr_clo  = bus.bus_wr && hit_clo;
  assign wr_chi  = bus.bus_wr && hit_chi;
  assign wr_ctl  = bus.bus_wr && hit_ctl;

  assign tick    = en && pcnt == div;

  assign ctrl_val = {{(31-PRESCALE_W){1'b0}}, div, en};

  // A half-write overrides the tick; the other half keeps its pre-tick value.
  always_comb begin
    mtime_n = tick ? mtime + 64'd1 : mtime;
    if (wr_tlo) mtime_n = {mtime[63:32], bus.bus_wdata};
    if (wr_thi) mtime_n = {bus.bus_wdata, mtime[31:0]};
  end

  always_comb begin
    cmp_n = mtimecmp;
    if (wr_clo) cmp_n[31:0]  = bus.bus_wdata;
    if (wr_chi) cmp_n[63:32] = bus.bus_wdata;
  end

  always_comb begin
    bus.bus_rdata = '0;
    if (bus.bus_rd) begin
      unique case (1'b1)
        hit_tlo: bus.bus_rdata = mtime[31:0];
        hit_thi: bus.bus_rdata = mtime[63:32];
        hit_clo: bus.bus_rdata = mtimecmp[31:0];
        hit_chi: bus.bus_rdata = mtimecmp[63:32];
        hit_ctl: bus.bus_rdata = ctrl_val;
        default: bus.bus_rdata = '0;
      endcase
    end
  end

  assign trap_req = timer_irq && glb_ie && !stall;
  assign intr_exc = state == IDLE && trap_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      en        <= 1'b0;
      div       <= '0;
      pcnt      <= '0;
      timer_irq <= 1'b0;
      state     <= IDLE;
    end else begin
      mtime     <= mtime_n;
      mtimecmp  <= cmp_n;
      timer_irq <= mtime_n >= cmp_n;
      if (wr_ctl) begin
        {div, en} <= bus.bus_wdata[PRESCALE_W:0];
      end
      if (wr_ctl || !en || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
      unique case (state)
        IDLE: if (trap_req) state <= TRAP;
        TRAP: if (mret)     state <= IDLE;
        default:            state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Scoreboard bench for timer_intr_ctrl: directed plan plus random traffic
// checked against a cycle-count reference model.
module tb_timer_intr_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic reset;
  logic glb_ie;
  logic stall;
  logic mret;
  logic timer_irq;
  logic intr_exc;

  timer_intr_ctrl_if bus ();

  timer_intr_ctrl #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .glb_ie    (glb_ie),
    .stall     (stall),
    .mret      (mret),
    .timer_irq (timer_irq),
    .intr_exc  (intr_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          sel;
    bit          irq;
    bit          intr;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: mtime advances once per (div+1) enabled cycles
  logic [63:0]     m_time;
  logic [63:0]     m_cmp;
  bit              m_en;
  int unsigned     m_div;
  longint unsigned m_since;
  bit              m_irq;
  bit              m_trap;

  function automatic void m_reset();
    m_time  = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en    = 1'b0;
    m_div   = 0;
    m_since = 0;
    m_irq   = 1'b0;
    m_trap  = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] o);
    case (o)
      5'h00:   return m_time[31:0];
      5'h04:   return m_time[63:32];
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return (m_div << 1) | 32'(m_en);
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_step(
    input bit wr, input logic [31:0] a,
    input logic [31:0] wd, input bit mr,
    input bit intr
  );
    bit          hit;
    bit          tick;
    logic [63:0] nt;
    hit  = wr && a[31:5] == BASE[31:5];
    tick = m_en &&
           (m_since % (m_div + 1)) == m_div;
    nt   = m_time;
    if (tick) nt = m_time + 64'd1;
    if (m_en) m_since++;
    else      m_since = 0;
    if (hit) begin
      case (a[4:0])
        5'h00: nt = {m_time[63:32], wd};
        5'h04: nt = {wd, m_time[31:0]};
        5'h08: m_cmp[31:0]  = wd;
        5'h0C: m_cmp[63:32] = wd;
        5'h10: begin
          m_en    = wd[0];
          m_div   = 32'(wd[8:1]);
          m_since = 0;
        end
        default: ;
      endcase
    end
    m_time = nt;
    m_irq  = m_time >= m_cmp;
    if (!m_trap && intr)   m_trap = 1'b1;
    else if (m_trap && mr) m_trap = 1'b0;
  endfunction

  function automatic void check(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  task automatic cyc(
    input bit wr, input bit rd,
    input logic [31:0] a, input logic [31:0] wd,
    input bit ie, input bit st, input bit mr
  );
    exp_t e;
    bus.bus_wr    = wr;
    bus.bus_rd    = rd;
    bus.bus_addr  = a;
    bus.bus_wdata = wd;
    glb_ie        = ie;
    stall         = st;
    mret          = mr;
    e.sel   = a[31:5] == BASE[31:5];
    e.rdata = (rd && e.sel) ? m_read(a[4:0]) : 32'd0;
    e.irq   = m_irq;
    e.intr  = !m_trap && m_irq && ie && !st;
    sb.push_back(e);
    @(posedge clk);
    m_step(wr, a, wd, mr, e.intr);
    #1;
  endtask

  task automatic wr32(input logic [4:0] o, input logic [31:0] d);
    cyc(1, 0, BASE + 32'(o), d, 0, 0, 0);
  endtask

  task automatic rd32(input logic [4:0] o, input bit ie,
                      input bit st, input bit mr);
    cyc(0, 1, BASE + 32'(o), 32'd0, ie, st, mr);
  endtask

  // monitor: one expectation per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata", bus.bus_rdata, e.rdata);
        check("bus_sel", 32'(bus.bus_sel), 32'(e.sel));
        check("timer_irq", 32'(timer_irq), 32'(e.irq));
        check("intr_exc", 32'(intr_exc), 32'(e.intr));
      end
    end
  end

  initial begin
    bit w;
    bit r;
    int k;
    logic [4:0]  o;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  offs [8];
    offs = '{5'h00, 5'h04, 5'h08, 5'h0C,
             5'h10, 5'h14, 5'h1C, 5'h02};

    m_reset();
    reset         = 1'b0;
    bus.bus_wr    = 1'b0;
    bus.bus_rd    = 1'b0;
    bus.bus_addr  = 32'd0;
    bus.bus_wdata = 32'd0;
    glb_ie        = 1'b0;
    stall         = 1'b0;
    mret          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // reset values
    for (int i = 0; i < 5; i++) rd32(5'(i * 4), 0, 0, 0);
    cyc(0, 1, BASE + 32'h20, 0, 0, 0, 0);

    // DIV=0 count to compare value 5 and trap
    wr32(5'h0C, 32'd0);
    wr32(5'h08, 32'd5);
    wr32(5'h10, 32'h1);
    for (int i = 0; i < 8; i++) rd32(5'h00, 1, 0, 0);
    // stall holds the request across the mret-to-idle return
    rd32(5'h00, 1, 1, 1);
    for (int i = 0; i < 3; i++) rd32(5'h00, 1, 1, 0);
    rd32(5'h00, 1, 0, 0);
    rd32(5'h00, 1, 0, 1);

    // async reset while intr_exc is asserted
    bus.bus_wr   = 1'b0;
    bus.bus_rd   = 1'b1;
    bus.bus_addr = BASE + 32'h08;
    glb_ie       = 1'b1;
    stall        = 1'b0;
    mret         = 1'b0;
    #1;
    check("pre_reset_intr", 32'(intr_exc), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_intr", 32'(intr_exc), 32'd0);
    check("rst_irq", 32'(timer_irq), 32'd0);
    check("rst_cmp_lo", bus.bus_rdata, 32'hFFFF_FFFF);
    m_reset();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) rd32(5'(i * 4), 1, 0, 0);

    // DIV=3: one increment per four cycles, then hold
    wr32(5'h10, 32'h7);
    for (int i = 0; i < 13; i++) rd32(5'h00, 0, 0, 0);
    wr32(5'h10, 32'h0);
    for (int i = 0; i < 4; i++) rd32(5'h00, 0, 0, 0);

    // 32-bit carry into the high half, then write-vs-tick
    wr32(5'h04, 32'd0);
    wr32(5'h00, 32'hFFFF_FFFF);
    wr32(5'h10, 32'h1);
    rd32(5'h00, 0, 0, 0);
    rd32(5'h04, 0, 0, 0);
    wr32(5'h00, 32'h1234);
    rd32(5'h00, 0, 0, 0);
    rd32(5'h04, 0, 0, 0);

    // 64-bit wrap to zero
    wr32(5'h10, 32'h0);
    wr32(5'h04, 32'hFFFF_FFFF);
    wr32(5'h00, 32'hFFFF_FFFF);
    wr32(5'h10, 32'h1);
    rd32(5'h04, 0, 0, 0);
    rd32(5'h04, 0, 0, 0);
    rd32(5'h00, 0, 0, 0);

    // compare write making irq false
    wr32(5'h0C, 32'hFFFF_FFFF);
    rd32(5'h0C, 0, 0, 0);
    rd32(5'h0C, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      o = offs[$urandom_range(0, 7)];
      a = (k == 0) ? BASE + 32'h20 + 32'(o)
                   : BASE + 32'(o);
      w = $urandom_range(0, 4) == 0;
      r = $urandom_range(0, 1) == 1;
      d = $urandom;
      if (o == 5'h10) d = {29'd0, d[1:0], 1'b1};
      if (o == 5'h0C || o == 5'h04) d = {30'd0, d[1:0]};
      if (o == 5'h08 && d[0]) d = {24'd0, d[7:0]};
      cyc(w, r, a, d,
          $urandom_range(0, 4) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 5) == 0);
    end

    bus.bus_wr = 1'b0;
    bus.bus_rd = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
